// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the dot-product PE sequencer.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PE_LAT = 3;
    localparam int RD_LAT = 1;
    localparam int PSUM_W = 25;

    // Flags that travel alongside each operand read until its p_sum appears.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/pe_out_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy count.
module pe_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // An empty FIFO presents zero rather than stale storage.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since the count gates the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer for the 4-tap PE: issues operand reads under FIFO credit,
// tracks in-flight reads with a tag pipeline and accumulates per output.
module pe_seq_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int GRP_W      = 8,
    parameter int OUT_W      = 16,
    parameter int ACC_W      = 32,
    parameter int PIPE_LAT   = RD_LAT + PE_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [GRP_W-1:0]         cfg_groups,
    input  logic [OUT_W-1:0]         cfg_outputs,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [GRP_W-1:0]         rd_grp,
    output logic [OUT_W-1:0]         rd_out,
    input  logic signed [PSUM_W-1:0] p_sum,
    output logic                     out_valid,
    output logic [ACC_W-1:0]         out_data,
    input  logic                     out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [GRP_W-1:0] GRP_ONE = GRP_W'(1);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PSUM_W-1:0] v);
        return {{(ACC_W - PSUM_W){v[PSUM_W-1]}}, v};
    endfunction

    state_t                  state;
    state_t                  next_state;
    logic [GRP_W-1:0]        groups_q;
    logic [GRP_W-1:0]        g;
    logic [OUT_W-1:0]        outputs_q;
    logic [OUT_W-1:0]        o;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    tag_t                    tag_pipe [0:PIPE_LAT];
    logic [CNT_W-1:0]        inflight_last;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          occupancy;
    logic                    last_grp;
    logic                    last_out;
    logic                    blocked;
    logic                    issue;
    logic                    pipe_busy;
    logic                    busy_d;
    logic                    done_d;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign last_grp  = (g == groups_q - GRP_ONE);
    assign last_out  = (o == outputs_q - OUT_ONE);
    // Every last-group read must own a FIFO slot by the time its sum lands,
    // because the PE cannot be stalled once the read is issued.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_last};
    assign blocked   = last_grp && (fifo_full || occupancy >= DEPTH_V);
    assign rd_en     = tag_pipe[0].valid;
    assign out_valid = !fifo_empty;
    assign pop       = out_ready && !fifo_empty;

    // Any read still travelling towards the PE output.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i <= PIPE_LAT; i++) pipe_busy = pipe_busy | tag_pipe[i].valid;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (cfg_outputs == '0) ? DONE : ISSUE;
            ISSUE:   if (!blocked && last_grp && last_out) next_state = DRAIN;
            DRAIN:   if (!pipe_busy) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: read issue and the next values of busy/done.
    always_comb begin
        issue  = (state == ISSUE) && !blocked;
        busy_d = (next_state != IDLE);
        done_d = (state == DONE);
    end

    // Accumulate the sum arriving with the oldest tag; first group restarts it.
    always_comb begin
        push = tag_pipe[PIPE_LAT].valid && tag_pipe[PIPE_LAT].last;
        sum  = tag_pipe[PIPE_LAT].first ? sext(p_sum) : acc + sext(p_sum);
    end

    // Run configuration, group/output counters, read address and credit tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            groups_q      <= '0;
            outputs_q     <= '0;
            g             <= '0;
            o             <= '0;
            rd_grp        <= '0;
            rd_out        <= '0;
            inflight_last <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (state == IDLE && start) begin
                groups_q  <= (cfg_groups == '0) ? GRP_ONE : cfg_groups;
                outputs_q <= cfg_outputs;
                g         <= '0;
                o         <= '0;
            end
            if (issue) begin
                rd_grp <= g;
                rd_out <= o;
                if (last_grp) begin
                    g <= '0;
                    o <= o + OUT_ONE;
                end else begin
                    g <= g + GRP_ONE;
                end
            end
            case ({issue && last_grp, push})
                2'b10:   inflight_last <= inflight_last + CNT_ONE;
                2'b01:   inflight_last <= inflight_last - CNT_ONE;
                default: inflight_last <= inflight_last;
            endcase
        end
    end

    // Tag pipeline: slot 0 rides with rd_en, slot PIPE_LAT lines up with p_sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIPE_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: issue, first: issue && (g == '0), last: issue && last_grp};
            for (int i = 1; i <= PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Accumulator register; idle tag slots leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      acc <= '0;
        else if (tag_pipe[PIPE_LAT].valid) acc <= sum;
    end

    pe_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ACC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (sum),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with a 1-cycle buffer and 3-stage PE model.
module tb_pe_seq_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         cfg_groups;
    logic [15:0]        cfg_outputs;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [7:0]         rd_grp;
    logic [15:0]        rd_out;
    logic signed [24:0] p_sum;
    logic               out_valid;
    logic [31:0]        out_data;
    logic               out_ready;

    pe_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_groups  (cfg_groups),
        .cfg_outputs (cfg_outputs),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_grp      (rd_grp),
        .rd_out      (rd_out),
        .p_sum       (p_sum),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // Buffer + PE model: every tap uses ifm = ifm_base + ifm_step*rd_out, wgt = wgt_val.
    int ifm_base = 0;
    int ifm_step = 0;
    int wgt_val  = 0;
    int st0 = 0, st1 = 0, st2 = 0, st3 = 0;
    always @(posedge clk) begin
        st0 <= rd_en ? 4 * (ifm_base + ifm_step * int'(rd_out)) * wgt_val : 777;
        st1 <= st0;
        st2 <= st1;
        st3 <= st2;
    end
    assign p_sum = st3[24:0];

    // Observers, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cnt = 0, rd_start = 0, rd_last = 0, ov_rise = 0, done_cnt = 0, done_cyc = 0;
    bit prev_rd = 1'b0, prev_ov = 1'b0;
    logic signed [31:0] got [$];
    always @(negedge clk) begin
        if (rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (!prev_rd) rd_start = cyc;
            rd_last = cyc;
        end
        prev_rd = rd_en;
        if (out_valid && !prev_ov) ov_rise = cyc;
        prev_ov = out_valid;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (out_valid && out_ready) got.push_back(out_data);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 'x;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int s_cyc;
    task automatic do_start(input int grp, input int outs);
        cfg_groups  = 8'(grp);
        cfg_outputs = 16'(outs);
        start       = 1'b1;
        s_cyc       = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int base;
        int n;
        base = done_cnt;
        n    = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        wait_cycles(6);
        check(tag, done_cnt - base, 1);
    endtask

    int rb, gb, db;

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        cfg_groups  = '0;
        cfg_outputs = '0;
        out_ready   = 1'b0;
        wait_cycles(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_grp", rd_grp, 0);
        check("rst_rd_out", rd_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        wait_cycles(2);

        // groups=9, outputs=1, ifm=1, wgt=2 -> 72; a second start mid-run is ignored.
        ifm_base = 1; ifm_step = 0; wgt_val = 2; out_ready = 1'b1;
        rb = rd_cnt; gb = got.size();
        do_start(9, 1);
        check("r1_busy_rise", busy, 1);
        wait_cycles(2);
        cfg_groups = 8'd3; cfg_outputs = 16'd5; start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        wait_done(100, "r1_done_once");
        check("r1_rd_count", rd_cnt - rb, 9);
        check("r1_rd_span", rd_last - rd_start, 8);
        check("r1_latency", ov_rise - rd_last, 5);
        check("r1_n_results", got.size() - gb, 1);
        check("r1_sum", got_at(gb), 72);
        check("r1_busy_fall", busy, 0);

        // groups=1, outputs=3, taps -128 x -128 -> 65536 each.
        ifm_base = -128; ifm_step = 0; wgt_val = -128;
        rb = rd_cnt; gb = got.size();
        do_start(1, 3);
        wait_done(100, "r2_done_once");
        check("r2_rd_count", rd_cnt - rb, 3);
        check("r2_rd_span", rd_last - rd_start, 2);
        check("r2_n_results", got.size() - gb, 3);
        for (int i = 0; i < 3; i++) check($sformatf("r2_sum%0d", i), got_at(gb + i), 65536);

        // groups=2, outputs=8, consumer stalled: issue stops at the 5th output's last group.
        ifm_base = 1; ifm_step = 1; wgt_val = 1; out_ready = 1'b0;
        rb = rd_cnt; gb = got.size(); db = done_cnt;
        do_start(2, 8);
        wait_cycles(30);
        check("r3_stall_reads", rd_cnt - rb, 9);
        wait_cycles(30);
        check("r3_stall_reads_hold", rd_cnt - rb, 9);
        check("r3_out_valid", out_valid, 1);
        check("r3_head", out_data, 8);
        check("r3_busy", busy, 1);
        check("r3_no_done", done_cnt - db, 0);
        out_ready = 1'b1;
        wait_done(200, "r3_done_once");
        check("r3_rd_count", rd_cnt - rb, 16);
        check("r3_n_results", got.size() - gb, 8);
        for (int i = 0; i < 8; i++) check($sformatf("r3_sum%0d", i), got_at(gb + i), 8 * (i + 1));

        // cfg_outputs=0: no reads, done two cycles after start.
        rb = rd_cnt; gb = got.size();
        do_start(4, 0);
        check("r4_busy", busy, 1);
        wait_done(20, "r4_done_once");
        check("r4_done_delay", done_cyc - s_cyc, 2);
        check("r4_rd_count", rd_cnt - rb, 0);
        check("r4_n_results", got.size() - gb, 0);

        // groups=4, outputs=4, reset mid-ISSUE, then a clean rerun -> 16,32,48,64.
        ifm_base = 1; ifm_step = 1; wgt_val = 1;
        gb = got.size();
        do_start(4, 4);
        wait_cycles(4);
        rst_n = 1'b0;
        #1;
        check("r5_rst_busy", busy, 0);
        check("r5_rst_done", done, 0);
        check("r5_rst_rd_en", rd_en, 0);
        check("r5_rst_rd_grp", rd_grp, 0);
        check("r5_rst_rd_out", rd_out, 0);
        check("r5_rst_out_valid", out_valid, 0);
        check("r5_rst_out_data", out_data, 0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(12);
        check("r5_discarded", got.size() - gb, 0);
        check("r5_idle_valid", out_valid, 0);
        rb = rd_cnt; gb = got.size();
        do_start(4, 4);
        wait_done(150, "r5_done_once");
        check("r5_rd_count", rd_cnt - rb, 16);
        check("r5_n_results", got.size() - gb, 4);
        for (int i = 0; i < 4; i++) check($sformatf("r5_sum%0d", i), got_at(gb + i), 16 * (i + 1));

        // groups=255, tap products -16384 -> -16711680.
        ifm_base = -128; ifm_step = 0; wgt_val = 128;
        rb = rd_cnt; gb = got.size();
        do_start(255, 1);
        wait_done(600, "r6_done_once");
        check("r6_rd_count", rd_cnt - rb, 255);
        check("r6_n_results", got.size() - gb, 1);
        check("r6_sum", got_at(gb), -16711680);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
